perimeter_n: RTL and testbench

- Parametrised N-channel perimeter accumulator, successor of the two-producer rectangle perimeter unit.
- Collects one side length from each of N producers over independent dav_/rfd handshakes, then sums them sequentially on a single adder.
- Optionally doubles the sum (rectangle mode).
- Delivers the result to one consumer over the same dav_/rfd handshake.
- Adds a runtime channel-enable mask, so polygons with fewer sides need no re-synthesis.

---
 rtl/perimeter_n.sv | 147 ++++++++++++++
 tb/tb_perimeter_n.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/perimeter_n.sv
// N-channel perimeter accumulator: collects one side per producer over dav_/rfd
// handshakes, sums them on a single adder, and hands the result to one consumer.
module perimeter_n #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int DOUBLE = 0,
    localparam int OW    = W + $clog2(N) + DOUBLE
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N*W-1:0]  data_in,
    input  logic [N-1:0]    dav_in_,
    output logic [N-1:0]    rfd_in,
    input  logic [N-1:0]    chan_en,
    output logic [OW-1:0]   data_out,
    output logic            dav_out_,
    input  logic            rfd_out
);

    localparam int AW = W + $clog2(N);
    localparam int KW = $clog2(N);

    typedef enum logic [2:0] {S_START, S_COLLECT, S_SUM, S_OUT_WAIT, S_OUT_ACK} state_t;
    typedef enum logic [1:0] {CH_IDLE, CH_HELD, CH_DONE} ch_t;

    state_t          state_q, state_d;
    ch_t             ch_q [N];
    ch_t             ch_d [N];
    logic [W-1:0]    side_q [N];
    logic [W-1:0]    side_d [N];
    logic [N-1:0]    en_q, en_d;
    logic [N-1:0]    rfd_q, rfd_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [KW-1:0]   k_q, k_d;
    logic [OW-1:0]   result_q, result_d;
    logic [OW-1:0]   data_out_q, data_out_d;
    logic            dav_out_q, dav_out_d;
    logic            all_done;
    logic [AW-1:0]   sum;

    // NOTE: every variable gets its default before the case so no path leaves
    // one unassigned; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        side_d     = side_q;
        en_d       = en_q;
        rfd_d      = rfd_q;
        acc_d      = acc_q;
        k_d        = k_q;
        result_d   = result_q;
        data_out_d = data_out_q;
        dav_out_d  = dav_out_q;
        sum        = acc_q + (en_q[k_q] ? AW'(side_q[k_q]) : '0);

        all_done = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (ch_q[i] != CH_DONE) all_done = 1'b0;
        end

        case (state_q)
            S_START: begin
                en_d  = chan_en;
                rfd_d = chan_en;
                // Disabled channels are born finished so they never gate the round.
                for (int i = 0; i < N; i++) begin
                    ch_d[i] = chan_en[i] ? CH_IDLE : CH_DONE;
                end
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                for (int i = 0; i < N; i++) begin
                    case (ch_q[i])
                        CH_IDLE: if (!dav_in_[i]) begin
                            side_d[i] = data_in[i*W +: W];
                            rfd_d[i]  = 1'b0;
                            ch_d[i]   = CH_HELD;
                        end
                        CH_HELD: if (dav_in_[i]) ch_d[i] = CH_DONE;
                        default: ;
                    endcase
                end
                if (all_done) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                acc_d = sum;
                k_d   = k_q + KW'(1);
                // The final addend is folded in here rather than a cycle later.
                if (k_q == KW'(N - 1)) begin
                    result_d = OW'(sum) << DOUBLE;
                    state_d  = S_OUT_WAIT;
                end
            end
            S_OUT_WAIT: if (rfd_out) begin
                data_out_d = result_q;
                dav_out_d  = 1'b0;
                state_d    = S_OUT_ACK;
            end
            S_OUT_ACK: if (!rfd_out) begin
                dav_out_d = 1'b1;
                state_d   = S_START;
            end
            default: state_d = S_START;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_START;
            en_q       <= '0;
            rfd_q      <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            result_q   <= '0;
            data_out_q <= '0;
            dav_out_q  <= 1'b1;
            for (int i = 0; i < N; i++) ch_q[i] <= CH_IDLE;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            en_q       <= en_d;
            rfd_q      <= rfd_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            result_q   <= result_d;
            data_out_q <= data_out_d;
            dav_out_q  <= dav_out_d;
        end
    end

    // NOTE: side storage is deliberately not reset; it is always written in
    // COLLECT before SUM reads it, and disabled entries are masked by en_q.
    always_ff @(posedge clock) begin
        side_q <= side_d;
    end

    assign rfd_in   = rfd_q;
    assign data_out = data_out_q;
    assign dav_out_ = dav_out_q;

endmodule

// File: tb/tb_perimeter_n.sv
// Directed bench for perimeter_n: a default N=4 plain-sum instance and an
// N=2 doubling instance, checked with immediate assertions.
module tb_perimeter_n;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] a_data_in;
    logic [3:0]  a_dav_in_, a_rfd_in, a_chan_en;
    logic [9:0]  a_data_out;
    logic        a_dav_out_, a_rfd_out;

    logic [15:0] b_data_in;
    logic [1:0]  b_dav_in_, b_rfd_in, b_chan_en;
    logic [9:0]  b_data_out;
    logic        b_dav_out_, b_rfd_out;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    perimeter_n #(.N(4), .W(8), .DOUBLE(0)) dut_a (
        .clock(clk), .reset(reset), .data_in(a_data_in), .dav_in_(a_dav_in_),
        .rfd_in(a_rfd_in), .chan_en(a_chan_en), .data_out(a_data_out),
        .dav_out_(a_dav_out_), .rfd_out(a_rfd_out)
    );

    perimeter_n #(.N(2), .W(8), .DOUBLE(1)) dut_b (
        .clock(clk), .reset(reset), .data_in(b_data_in), .dav_in_(b_dav_in_),
        .rfd_in(b_rfd_in), .chan_en(b_chan_en), .data_out(b_data_out),
        .dav_out_(b_dav_out_), .rfd_out(b_rfd_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int ch, input logic [7:0] val);
        int n = 0;
        while (!a_rfd_in[ch] && n < 100) begin tick(1); n++; end
        check("a rfd_in ready", 32'(a_rfd_in[ch]), 1);
        a_data_in[ch*8 +: 8] = val;
        a_dav_in_[ch] = 1'b0;
        tick(1);
        check("a rfd_in drop", 32'(a_rfd_in[ch]), 0);
        a_dav_in_[ch] = 1'b1;
        tick(1);
    endtask

    // Accepts the A result, loads the next mask, and checks rfd_in after START.
    task automatic take_a(input string tag, input logic [9:0] exp, input logic [3:0] next_en);
        int n = 0;
        a_rfd_out = 1'b1;
        while (a_dav_out_ && n < 200) begin tick(1); n++; end
        check({tag, " dav_out_ low"}, 32'(a_dav_out_), 0);
        check({tag, " data_out"}, 32'(a_data_out), 32'(exp));
        a_chan_en = next_en;
        a_rfd_out = 1'b0;
        tick(1);
        check({tag, " dav_out_ high"}, 32'(a_dav_out_), 1);
        tick(1);
        check({tag, " rfd_in next"}, 32'(a_rfd_in), 32'(next_en));
    endtask

    task automatic take_b(input string tag, input logic [9:0] exp);
        int n = 0;
        b_rfd_out = 1'b1;
        while (b_dav_out_ && n < 200) begin tick(1); n++; end
        check({tag, " dav_out_ low"}, 32'(b_dav_out_), 0);
        check({tag, " data_out"}, 32'(b_data_out), 32'(exp));
        b_rfd_out = 1'b0;
        tick(2);
        check({tag, " rfd_in next"}, 32'(b_rfd_in), 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        a_data_in = '0; a_dav_in_ = '1; a_chan_en = 4'b1111; a_rfd_out = 1'b0;
        b_data_in = '0; b_dav_in_ = '1; b_chan_en = 2'b11;   b_rfd_out = 1'b0;

        // Reset held for 3 cycles.
        tick(3);
        check("reset rfd_in", 32'(a_rfd_in), 0);
        check("reset dav_out_", 32'(a_dav_out_), 1);
        check("reset data_out", 32'(a_data_out), 0);
        reset = 1'b0;
        tick(1);
        check("start rfd_in", 32'(a_rfd_in), 4'b1111);

        // Sides 3,4,5,6 together; exact latency from last dav_ rise.
        a_data_in = {8'd6, 8'd5, 8'd4, 8'd3};
        a_dav_in_ = 4'b0000;
        tick(1);
        check("all capture rfd_in", 32'(a_rfd_in), 0);
        a_dav_in_ = 4'b1111;
        a_rfd_out = 1'b1;
        @(posedge clk);
        tick(5);
        check("lat dav_out_ still high", 32'(a_dav_out_), 1);
        tick(1);
        check("lat dav_out_ low", 32'(a_dav_out_), 0);
        check("sum 3+4+5+6", 32'(a_data_out), 18);
        a_rfd_out = 1'b0;
        tick(1);
        check("ack dav_out_ high", 32'(a_dav_out_), 1);
        check("ack rfd_in low", 32'(a_rfd_in), 0);
        tick(1);
        check("rfd_in reassert", 32'(a_rfd_in), 4'b1111);

        // All 255, out of order with gaps; consumer already ready.
        a_rfd_out = 1'b1;
        send_a(2, 8'd255); check("ord rfd after ch2", 32'(a_rfd_in), 4'b1011); tick(2);
        send_a(0, 8'd255); check("ord rfd after ch0", 32'(a_rfd_in), 4'b1010); tick(3);
        send_a(3, 8'd255); check("ord rfd after ch3", 32'(a_rfd_in), 4'b0010); tick(4);
        check("no early output", 32'(a_dav_out_), 1);
        send_a(1, 8'd255); check("ord rfd after ch1", 32'(a_rfd_in), 4'b0000);
        take_a("max", 10'd1020, 4'b0111);

        // Masked channel 3 carries junk that must be ignored.
        a_data_in[31:24] = 8'd99;
        send_a(0, 8'd10);
        send_a(1, 8'd20);
        check("mask rfd_in[3] low", 32'(a_rfd_in[3]), 0);
        send_a(2, 8'd30);
        take_a("mask", 10'd60, 4'b0000);

        // Empty mask: result with no input handshake.
        take_a("empty", 10'd0, 4'b1111);

        // Doubling instance: consumer withheld until well after SUM.
        b_data_in = {8'd6, 8'd5};
        b_dav_in_ = 2'b00;
        tick(1);
        b_dav_in_ = 2'b11;
        tick(10);
        check("b held dav_out_", 32'(b_dav_out_), 1);
        take_b("b double", 10'd22);
        b_data_in = {8'd255, 8'd255};
        b_dav_in_ = 2'b00;
        tick(1);
        b_dav_in_ = 2'b11;
        take_b("b max", 10'd1020);

        // Reset while one channel sits in HELD; stale capture must not leak.
        a_data_in[15:8] = 8'd200;
        a_dav_in_[1] = 1'b0;
        tick(1);
        check("held rfd_in", 32'(a_rfd_in), 4'b1101);
        reset = 1'b1;
        tick(1);
        a_dav_in_[1] = 1'b1;
        check("midreset rfd_in", 32'(a_rfd_in), 0);
        reset = 1'b0;
        tick(1);
        check("post reset rfd_in", 32'(a_rfd_in), 4'b1111);
        a_rfd_out = 1'b1;
        tick(8);
        check("post reset no output", 32'(a_dav_out_), 1);
        for (int i = 0; i < 4; i++) send_a(i, 8'd1);
        take_a("fresh", 10'd4, 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
